// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and stage indices for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } hctrl_state_e;

  // Stage indices, youngest (PC) to oldest (commit).
  localparam int STG_PC      = 0;
  localparam int STG_IF_ID   = 1;
  localparam int STG_ID_IS   = 2;
  localparam int STG_IQ      = 3;
  localparam int STG_IS_EX   = 4;
  localparam int STG_EX_MEM  = 5;
  localparam int STG_MEM_CMT = 6;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Request/strobe bundle between the pipeline stages and the hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int NUM_STAGES = 7,
  parameter int CNT_W      = 32
);
  logic [NUM_STAGES-1:0] stall_req_i;
  logic [NUM_STAGES-1:0] flush_req_i;
  logic [NUM_STAGES-1:0] stall_o;
  logic [NUM_STAGES-1:0] bubble_o;
  logic [NUM_STAGES-1:0] flush_o;
  logic                  flush_busy_o;
  logic                  stall_timeout_o;
  logic [CNT_W-1:0]      stall_cycles_o;

  // Pipeline side: raises requests, consumes strobes.
  modport master (
    output stall_req_i, flush_req_i,
    input  stall_o, bubble_o, flush_o, flush_busy_o, stall_timeout_o, stall_cycles_o
  );

  // Controller side.
  modport slave (
    input  stall_req_i, flush_req_i,
    output stall_o, bubble_o, flush_o, flush_busy_o, stall_timeout_o, stall_cycles_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl_wdog.sv
// Stall deadlock watchdog (saturating run-length counter, sticky flag)
// and free-running stall-cycle performance counter.
module pipe_ctrl_wdog #(
  parameter int WDOG_LIMIT = 1024,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             any_stall,
  output logic             stall_timeout_o,
  output logic [CNT_W-1:0] stall_cycles_o
);
  localparam int WD_W = $clog2(WDOG_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_LIMIT);

  logic [WD_W-1:0]  wd_cnt, wd_nxt;
  logic             timeout_q;
  logic [CNT_W-1:0] cycles_q;

  // Run length of consecutive stalled cycles, held at the limit once reached.
  always_comb begin
    wd_nxt = '0;
    if (any_stall)
      wd_nxt = (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + 1'b1;
  end

  // Watchdog, sticky timeout (only reset clears it) and wrapping perf counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
      cycles_q  <= '0;
    end else begin
      wd_cnt <= wd_nxt;
      if (wd_nxt == WD_MAX) timeout_q <= 1'b1;
      if (any_stall)        cycles_q  <= cycles_q + 1'b1;
    end
  end

  assign stall_timeout_o = timeout_q;
  assign stall_cycles_o  = cycles_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: per-stage stall requests become
// hold/bubble strobes, flush requests squash all younger stages and are
// stretched over a FLUSH_HOLD window; a watchdog flags stall deadlock.
import pipe_ctrl_pkg::*;

module pipe_hazard_ctrl #(
  parameter int NUM_STAGES = 7,
  parameter int FLUSH_HOLD = 2,
  parameter int WDOG_LIMIT = 1024,
  parameter int CNT_W      = 32
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int HC_W = (FLUSH_HOLD > 0) ? $clog2(FLUSH_HOLD + 1) : 1;
  localparam logic [HC_W-1:0] HC_LOAD = HC_W'(FLUSH_HOLD);

  hctrl_state_e          state, state_nxt;
  logic [NUM_STAGES-1:0] hold_mask, mask_nxt;
  logic [HC_W-1:0]       hold_cnt, cnt_nxt;

  logic [NUM_STAGES-1:0] eff_flush, flush_m, flush_v;
  logic [NUM_STAGES-1:0] eff_stall, stall_th, bubble_v;

  // Flush mask: every stage strictly younger than the oldest unmasked requester.
  // Masked stages are already being squashed and cannot originate a flush.
  always_comb begin
    logic acc;
    eff_flush = hz.flush_req_i & ~hold_mask;
    flush_m   = '0;
    acc       = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      flush_m[i] = acc;
      acc        = acc | eff_flush[i];
    end
    flush_v = flush_m | hold_mask;
  end

  // Stall thermometer up to the oldest surviving stall; bubble goes one stage older.
  // Flushed stages neither stall nor bubble.
  always_comb begin
    logic acc;
    eff_stall = hz.stall_req_i & ~flush_v;
    stall_th  = '0;
    bubble_v  = '0;
    acc       = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      acc         = acc | eff_stall[i];
      stall_th[i] = acc;
    end
    for (int i = 1; i < NUM_STAGES; i++)
      bubble_v[i] = stall_th[i-1] & ~stall_th[i];
  end

  // FSM state, squash window mask and window counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      hold_mask <= '0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      hold_mask <= mask_nxt;
      hold_cnt  <= cnt_nxt;
    end
  end

  // Next state: any unmasked flush (re)opens the window; an older one widens the mask.
  always_comb begin
    state_nxt = state;
    mask_nxt  = hold_mask;
    cnt_nxt   = hold_cnt;
    case (state)
      RUN: begin
        if ((|eff_flush) && (FLUSH_HOLD > 0)) begin
          state_nxt = FLUSH;
          mask_nxt  = flush_m;
          cnt_nxt   = HC_LOAD;
        end
      end
      FLUSH: begin
        if (|eff_flush) begin
          mask_nxt = hold_mask | flush_m;
          cnt_nxt  = HC_LOAD;
        end else if (hold_cnt == HC_W'(1)) begin
          state_nxt = RUN;
          mask_nxt  = '0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = hold_cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = RUN;
        mask_nxt  = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs: flush beats stall on every stage it covers.
  always_comb begin
    hz.flush_o      = flush_v;
    hz.stall_o      = stall_th & ~flush_v;
    hz.bubble_o     = bubble_v & ~flush_v;
    hz.flush_busy_o = (state == FLUSH);
  end

  pipe_ctrl_wdog #(
    .WDOG_LIMIT (WDOG_LIMIT),
    .CNT_W      (CNT_W)
  ) u_wdog (
    .clk             (clk),
    .rst_n           (rst_n),
    .any_stall       (|hz.stall_req_i),
    .stall_timeout_o (hz.stall_timeout_o),
    .stall_cycles_o  (hz.stall_cycles_o)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl (7 stages, FLUSH_HOLD=2, WDOG_LIMIT=8).
module tb_pipe_hazard_ctrl;
  localparam int NS = 7;

  typedef struct {
    logic [NS-1:0] s, f;
    logic [NS-1:0] es, eb, ef;
    logic          ebusy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   model_cycles = 0;
  vec_t exp_q[$];
  vec_t tbl[10];

  pipe_hazard_ctrl_if #(.NUM_STAGES(NS), .CNT_W(32)) hif ();

  pipe_hazard_ctrl #(
    .NUM_STAGES (NS),
    .FLUSH_HOLD (2),
    .WDOG_LIMIT (8),
    .CNT_W      (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif.slave)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of requests; expected strobes go through the scoreboard
  // and are compared mid-cycle, then the clock edge is taken.
  task automatic step(input string name, input logic [NS-1:0] s, f,
                      input logic [NS-1:0] es, eb, ef, input logic ebusy);
    vec_t e;
    e.s = s; e.f = f; e.es = es; e.eb = eb; e.ef = ef; e.ebusy = ebusy;
    hif.stall_req_i = s;
    hif.flush_req_i = f;
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    cmp({name, ".stall"},  32'(hif.stall_o),  32'(e.es));
    cmp({name, ".bubble"}, 32'(hif.bubble_o), 32'(e.eb));
    cmp({name, ".flush"},  32'(hif.flush_o),  32'(e.ef));
    cmp({name, ".busy"},   32'(hif.flush_busy_o), 32'(e.ebusy));
    @(posedge clk);
    #1;
    if (s != '0) model_cycles++;
  endtask

  task automatic idle(input int n);
    hif.stall_req_i = '0;
    hif.flush_req_i = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    //        stall_req    flush_req    exp stall    exp bubble   exp flush    busy
    tbl[0] = '{7'b0010000, 7'b0000000, 7'b0011111, 7'b0100000, 7'b0000000, 1'b0};
    tbl[1] = '{7'b1000000, 7'b0000000, 7'b1111111, 7'b0000000, 7'b0000000, 1'b0};
    tbl[2] = '{7'b0000001, 7'b0000000, 7'b0000001, 7'b0000010, 7'b0000000, 1'b0};
    tbl[3] = '{7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 1'b0};
    tbl[4] = '{7'b0100100, 7'b0000000, 7'b0111111, 7'b1000000, 7'b0000000, 1'b0};
    tbl[5] = '{7'b0000100, 7'b0010000, 7'b0000000, 7'b0000000, 7'b0001111, 1'b0};
    tbl[6] = '{7'b0100000, 7'b0010000, 7'b0110000, 7'b1000000, 7'b0001111, 1'b0};
    tbl[7] = '{7'b0000000, 7'b0000001, 7'b0000000, 7'b0000000, 7'b0000000, 1'b0};
    tbl[8] = '{7'b0000000, 7'b1000000, 7'b0000000, 7'b0000000, 7'b0111111, 1'b0};
    tbl[9] = '{7'b0000000, 7'b0001010, 7'b0000000, 7'b0000000, 7'b0000111, 1'b0};

    hif.stall_req_i = '0;
    hif.flush_req_i = '0;
    #12;
    cmp("reset.flush",   32'(hif.flush_o), 32'd0);
    cmp("reset.busy",    32'(hif.flush_busy_o), 32'd0);
    cmp("reset.timeout", 32'(hif.stall_timeout_o), 32'd0);
    cmp("reset.cycles",  hif.stall_cycles_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-cycle vectors from RUN, each followed by enough idle to drain a flush window.
    for (int i = 0; i < 10; i++) begin
      step($sformatf("tbl%0d", i), tbl[i].s, tbl[i].f, tbl[i].es, tbl[i].eb, tbl[i].ef, tbl[i].ebusy);
      idle(3);
    end
    cmp("tbl.cycles", hif.stall_cycles_o, 32'(model_cycles));

    // Flush window stretched over two extra cycles.
    step("fl_t0", 7'b0000000, 7'b0010000, 7'b0, 7'b0, 7'b0001111, 1'b0);
    step("fl_t1", 7'b0000000, 7'b0000000, 7'b0, 7'b0, 7'b0001111, 1'b1);
    step("fl_t2", 7'b0000000, 7'b0000000, 7'b0, 7'b0, 7'b0001111, 1'b1);
    step("fl_t3", 7'b0000000, 7'b0000000, 7'b0, 7'b0, 7'b0000000, 1'b0);
    idle(1);

    // Older flush widens the window; younger flush inside it is ignored.
    step("old_t0", 7'b0000000, 7'b0001000, 7'b0, 7'b0, 7'b0000111, 1'b0);
    step("old_t1", 7'b0000000, 7'b0100000, 7'b0, 7'b0, 7'b0011111, 1'b1);
    step("old_t2", 7'b0000000, 7'b0000010, 7'b0, 7'b0, 7'b0011111, 1'b1);
    step("old_t3", 7'b0000000, 7'b0000000, 7'b0, 7'b0, 7'b0011111, 1'b1);
    step("old_t4", 7'b0000000, 7'b0000000, 7'b0, 7'b0, 7'b0000000, 1'b0);
    idle(1);

    // Flush in the last window cycle reloads; stall outside the mask still applies.
    step("rl_t0", 7'b0000000, 7'b0010000, 7'b0, 7'b0, 7'b0001111, 1'b0);
    step("rl_t1", 7'b0000000, 7'b0000000, 7'b0, 7'b0, 7'b0001111, 1'b1);
    step("rl_t2", 7'b0000000, 7'b1000000, 7'b0, 7'b0, 7'b0111111, 1'b1);
    step("rl_t3", 7'b1000000, 7'b0000000, 7'b1000000, 7'b0, 7'b0111111, 1'b1);
    step("rl_t4", 7'b0000000, 7'b0000000, 7'b0, 7'b0, 7'b0111111, 1'b1);
    step("rl_t5", 7'b0000000, 7'b0000000, 7'b0, 7'b0, 7'b0000000, 1'b0);
    idle(2);

    // Oldest stage held stalled for WDOG_LIMIT cycles.
    for (int k = 1; k <= 8; k++) begin
      step($sformatf("wd%0d", k), 7'b1000000, 7'b0, 7'b1111111, 7'b0, 7'b0, 1'b0);
      if (k == 7) cmp("wd.pre_timeout", 32'(hif.stall_timeout_o), 32'd0);
    end
    cmp("wd.timeout", 32'(hif.stall_timeout_o), 32'd1);
    idle(2);
    cmp("wd.sticky", 32'(hif.stall_timeout_o), 32'd1);
    cmp("wd.cycles", hif.stall_cycles_o, 32'(model_cycles));

    // Reset asserted inside a flush window.
    step("rst_t0", 7'b0000000, 7'b0010000, 7'b0, 7'b0, 7'b0001111, 1'b0);
    hif.flush_req_i = '0;
    #1;
    cmp("rst.pre_busy", 32'(hif.flush_busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    model_cycles = 0;
    cmp("rst.flush",   32'(hif.flush_o), 32'd0);
    cmp("rst.busy",    32'(hif.flush_busy_o), 32'd0);
    cmp("rst.timeout", 32'(hif.stall_timeout_o), 32'd0);
    cmp("rst.cycles",  hif.stall_cycles_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("post_rst", 7'b0000100, 7'b0, 7'b0000111, 7'b0001000, 7'b0, 1'b0);
    cmp("post_rst.cycles", hif.stall_cycles_o, 32'(model_cycles));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
